// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor using a single full-adder slice and a carry flip-flop.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CW-1:0] cnt_q;
  logic c_q, cy_q, ov_q;
  logic accept, last, s, co;
  always_comb begin
    accept = start && (state_q != RUN);
    last = cnt_q == CW'(WIDTH - 1);
    s = a_q[0] ^ b_q[0] ^ c_q;
    co = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    state_d = accept ? RUN : (state_q == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  // Subtraction is a + ~b + 1: B is inverted on capture and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      c_q <= 1'b0;
      cy_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= a;
        b_q <= mode ? ~b : b;
        c_q <= mode;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        a_q <= a_q >> 1;
        b_q <= b_q >> 1;
        c_q <= co;
        res_q <= {s, res_q[WIDTH-1:1]};
        cnt_q <= last ? cnt_q : cnt_q + CW'(1);
        if (last) begin
          cy_q <= co;
          ov_q <= c_q ^ co;
        end
      end
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign result = res_q;
  assign carry_out = cy_q;
  assign overflow = ov_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and random checks of serial_add_sub at WIDTH 8 and an exhaustive WIDTH 4 sweep.
module tb_serial_add_sub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy8, done8, cy8, ov8;
  logic [7:0] res8;
  logic start4 = 1'b0, mode4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic busy4, done4, cy4, ov4;
  logic [3:0] res4;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .carry_out(cy8), .overflow(ov8)
  );
  serial_add_sub #(.WIDTH(4)) d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .carry_out(cy4), .overflow(ov4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference from arithmetic on integers: unsigned carry/borrow and signed range overflow.
  function automatic void model(input int w, input int x, input int y, input bit m,
                                output int r, output bit cy, output bit ov);
    longint mask, half, sx, sy, u, sr;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sx = (x >= half) ? x - 2 * half : x;
    sy = (y >= half) ? y - 2 * half : y;
    u = m ? longint'(x) - y : longint'(x) + y;
    r = int'(u & mask);
    cy = m ? (x >= y) : (u > mask);
    sr = m ? sx - sy : sx + sy;
    ov = (sr < -half) || (sr >= half);
  endfunction

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input bit tm, input bit pulse);
    int r;
    bit cy, ov;
    model(8, int'(ta), int'(tb), tm, r, cy, ov);
    a8 = ta; b8 = tb; mode8 = tm; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); mode8 = ~tm;
    for (int i = 0; i < 8; i++) begin
      check("busy8_run", busy8, 1);
      check("done8_early", done8, 0);
      if (pulse) start8 = (i == 2);
      tick();
    end
    start8 = 1'b0;
    check("done8", done8, 1);
    check("busy8_end", busy8, 0);
    check("result8", res8, r);
    check("carry8", cy8, cy);
    check("ovf8", ov8, ov);
    tick();
    check("done8_pulse", done8, 0);
    check("result8_hold", res8, r);
    check("carry8_hold", cy8, cy);
  endtask

  initial begin
    int r;
    bit cy, ov;
    tick();
    tick();
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_res8", res8, 0);
    check("rst_cy8", cy8, 0);
    check("rst_ov8", ov8, 0);
    check("rst_busy4", busy4, 0);
    check("rst_res4", res4, 0);
    rst_n = 1'b1;
    tick();
    run8(8'h35, 8'h4A, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);
    run8(8'h05, 8'h07, 1'b1, 1'b0);
    run8(8'h35, 8'h4A, 1'b1, 1'b1);
    for (int n = 0; n < 24; n++)
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), n % 3 == 0);
    run8(8'h80, 8'h01, 1'b1, 1'b0);
    // Abort an operation on its fourth RUN cycle.
    a8 = 8'h12; b8 = 8'h34; mode8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", busy8, 0);
    check("abort_res", res8, 0);
    check("abort_done", done8, 0);
    check("abort_cy", cy8, 0);
    check("abort_ov", ov8, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort_no_done", done8, 0);
    end
    run8(8'h9C, 8'h27, 1'b0, 1'b0);
    // Exhaustive WIDTH 4 sweep, start held high so operations run back-to-back.
    a4 = 4'd0; b4 = 4'd0; mode4 = 1'b0; start4 = 1'b1;
    tick();
    for (int n = 0; n < 512; n++) begin
      model(4, n % 16, (n / 16) % 16, (n / 256) % 2 == 1, r, cy, ov);
      for (int i = 0; i < 4; i++) begin
        check("busy4_run", busy4, 1);
        check("done4_early", done4, 0);
        tick();
      end
      check("done4", done4, 1);
      check("busy4_end", busy4, 0);
      check("result4", res4, r);
      check("carry4", cy4, cy);
      check("ovf4", ov4, ov);
      if (n == 511) start4 = 1'b0;
      else begin
        a4 = 4'((n + 1) % 16);
        b4 = 4'(((n + 1) / 16) % 16);
        mode4 = ((n + 1) / 256) % 2 == 1;
      end
      tick();
    end
    check("done4_final", done4, 0);
    check("busy4_final", busy4, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
